instr_seq_ctrl: RTL

Instruction sequencer and decoder for the PIC16F core. It runs the four-phase Q1–Q4 instruction cycle and latches each fetched 14-bit instruction into an instruction register (IR). It decodes the IR into `alu` controls (op, operand select, status write enable) and Q4 write strobes, and resolves skips, branches, call and return by flushing the prefetched instruction. It sits directly upstream of `alu`, between program memory / PC and the datapath.

---
 rtl/instr_seq_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/instr_seq_ctrl.sv
// PIC16F instruction sequencer: Q1-Q4 phase counter, instruction register,
// instruction decode and skip/branch flush control.
module instr_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] instr,
  input  logic        alu_out_z,
  input  logic        alu_bit_test_res,
  output logic [1:0]  q_phase,
  output logic [3:0]  alu_op,
  output logic        alu_status_wr_en,
  output logic        lf_sel,
  output logic [7:0]  literal,
  output logic [6:0]  f_addr,
  output logic [2:0]  bit_sel,
  output logic        w_wr_en,
  output logic        f_wr_en,
  output logic        f_bit_set,
  output logic        f_bit_clr,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        pc_load_src,
  output logic [10:0] pc_load_addr,
  output logic        stack_push,
  output logic        stack_pop,
  output logic        ir_load
);

  localparam int unsigned IW = 14;

  localparam logic [3:0] alu_op_passw  = 4'd0;
  localparam logic [3:0] alu_op_passlf = 4'd1;
  localparam logic [3:0] alu_op_add    = 4'd2;
  localparam logic [3:0] alu_op_sub    = 4'd3;
  localparam logic [3:0] alu_op_and    = 4'd4;
  localparam logic [3:0] alu_op_or     = 4'd5;
  localparam logic [3:0] alu_op_xor    = 4'd6;
  localparam logic [3:0] alu_op_com    = 4'd7;
  localparam logic [3:0] alu_op_inc    = 4'd8;
  localparam logic [3:0] alu_op_dec    = 4'd9;
  localparam logic [3:0] alu_op_rlf    = 4'd10;
  localparam logic [3:0] alu_op_rrf    = 4'd11;
  localparam logic [3:0] alu_op_swapf  = 4'd12;
  localparam logic [3:0] alu_op_clr    = 4'd13;

  typedef enum logic [1:0] {q1 = 2'd0, q2 = 2'd1, q3 = 2'd2, q4 = 2'd3} q_t;

  q_t            q, q_nxt;
  logic [IW-1:0] ir, ir_nxt;
  logic          flush, flush_nxt;

  logic       dec_st, dec_dest, dec_w, dec_bs, dec_bc, dec_ld, dec_push, dec_pop;
  logic       skip_z, skip_clr, skip_set, skip, exec_q4;

  // Phase counter, IR and flush flag; the latter two move only on Q4->Q1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= q1;
      ir    <= '0;
      flush <= 1'b1;
    end else begin
      q     <= q_nxt;
      ir    <= ir_nxt;
      flush <= flush_nxt;
    end
  end

  // Instruction decode, purely from IR
  always_comb begin
    alu_op      = alu_op_passw;
    lf_sel      = 1'b0;
    pc_load_src = 1'b0;
    dec_st      = 1'b0;
    dec_dest    = 1'b0;
    dec_w       = 1'b0;
    dec_bs      = 1'b0;
    dec_bc      = 1'b0;
    dec_ld      = 1'b0;
    dec_push    = 1'b0;
    dec_pop     = 1'b0;
    skip_z      = 1'b0;
    skip_clr    = 1'b0;
    skip_set    = 1'b0;
    case (ir[13:12])
      2'b00: begin
        dec_dest = 1'b1;
        case (ir[11:8])
          4'b0111: begin alu_op = alu_op_add;    dec_st = 1'b1; end
          4'b0101: begin alu_op = alu_op_and;    dec_st = 1'b1; end
          4'b0001: begin alu_op = alu_op_clr;    dec_st = 1'b1; end
          4'b1001: begin alu_op = alu_op_com;    dec_st = 1'b1; end
          4'b0011: begin alu_op = alu_op_dec;    dec_st = 1'b1; end
          4'b1011: begin alu_op = alu_op_dec;    skip_z = 1'b1; end
          4'b1010: begin alu_op = alu_op_inc;    dec_st = 1'b1; end
          4'b1111: begin alu_op = alu_op_inc;    skip_z = 1'b1; end
          4'b0100: begin alu_op = alu_op_or;     dec_st = 1'b1; end
          4'b1000: begin alu_op = alu_op_passlf; dec_st = 1'b1; end
          4'b1101: begin alu_op = alu_op_rlf;    dec_st = 1'b1; end
          4'b1100: begin alu_op = alu_op_rrf;    dec_st = 1'b1; end
          4'b0010: begin alu_op = alu_op_sub;    dec_st = 1'b1; end
          4'b1110: begin alu_op = alu_op_swapf;  end
          4'b0110: begin alu_op = alu_op_xor;    dec_st = 1'b1; end
          default: begin
            // op 0000: MOVWF when d=1, otherwise NOP group incl. RETURN/RETFIE
            dec_dest = ir[7];
            if (!ir[7] && (ir == 14'h0008 || ir == 14'h0009)) begin
              dec_pop     = 1'b1;
              dec_ld      = 1'b1;
              pc_load_src = 1'b1;
            end
          end
        endcase
      end
      2'b01: begin
        alu_op = alu_op_passlf;
        case (ir[11:10])
          2'b00:   dec_bc   = 1'b1;
          2'b01:   dec_bs   = 1'b1;
          2'b10:   skip_clr = 1'b1;
          default: skip_set = 1'b1;
        endcase
      end
      2'b10: begin
        dec_ld   = 1'b1;
        dec_push = !ir[11];
      end
      default: begin
        lf_sel = 1'b1;
        dec_w  = 1'b1;
        casez (ir[11:8])
          4'b00??: alu_op = alu_op_passlf;
          4'b01??: begin
            alu_op      = alu_op_passlf;
            dec_pop     = 1'b1;
            dec_ld      = 1'b1;
            pc_load_src = 1'b1;
          end
          4'b1000: begin alu_op = alu_op_or;  dec_st = 1'b1; end
          4'b1001: begin alu_op = alu_op_and; dec_st = 1'b1; end
          4'b1010: begin alu_op = alu_op_xor; dec_st = 1'b1; end
          4'b110?: begin alu_op = alu_op_sub; dec_st = 1'b1; end
          4'b111?: begin alu_op = alu_op_add; dec_st = 1'b1; end
          default: begin alu_op = alu_op_passw; dec_w = 1'b0; lf_sel = 1'b0; end
        endcase
      end
    endcase
  end

  assign literal      = ir[7:0];
  assign f_addr       = ir[6:0];
  assign bit_sel      = ir[9:7];
  assign pc_load_addr = ir[10:0];

  // Next state and phase-gated strobes; a flushed cycle suppresses all effects
  always_comb begin
    q_nxt     = q;
    ir_nxt    = ir;
    flush_nxt = flush;
    skip      = (skip_z & alu_out_z) | (skip_clr & !alu_bit_test_res) |
                (skip_set & alu_bit_test_res);
    exec_q4   = (q == q4) && !flush;
    case (q)
      q1:      q_nxt = q2;
      q2:      q_nxt = q3;
      q3:      q_nxt = q4;
      default: begin
        q_nxt     = q1;
        ir_nxt    = instr;
        flush_nxt = !flush && (dec_ld || skip);
      end
    endcase
    q_phase          = 2'(q);
    alu_status_wr_en = dec_st && !flush;
    pc_inc           = (q == q1);
    ir_load          = (q == q4);
    w_wr_en          = exec_q4 && (dec_w || (dec_dest && !ir[7]));
    f_wr_en          = exec_q4 && dec_dest && ir[7];
    f_bit_set        = exec_q4 && dec_bs;
    f_bit_clr        = exec_q4 && dec_bc;
    pc_load          = exec_q4 && dec_ld;
    stack_push       = exec_q4 && dec_push;
    stack_pop        = exec_q4 && dec_pop;
  end

endmodule
